// File: rtl/uart_frame_parser.sv
// uart_frame_parser: byte-level framing stage behind a UART receiver.
// Hunts SYNC_BYTE, checks LEN and the 8-bit checksum, buffers the payload,
// then streams it out over valid/ready. Bad or stalled frames are dropped
// and reported through frame_err/err_code.
// Optional build macro PARSER_STATS_EN adds saturating ok_count/err_count outputs.
//
// Output handshake: out_valid rises together with out_data/out_last and stays
// high until a rising clk edge sees out_valid && out_ready (one transfer);
// out_data/out_last never change while out_valid && !out_ready.
module uart_frame_parser #(
    parameter int         BASE_FREQ     = 50_000_000,
    parameter int         BAUDRATE      = 115_200,
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
`ifdef PARSER_STATS_EN
    ,
    output logic [15:0] ok_count,
    output logic [15:0] err_count
`endif
);

    localparam int BYTE_CYCLES    = 10 * (BASE_FREQ / BAUDRATE);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * BYTE_CYCLES;
    localparam int IW             = $clog2(MAX_LEN + 1);
    localparam int AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0]    MAX_LEN_B    = 8'(MAX_LEN);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_LENGTH  = 2'b01;
    localparam logic [1:0] ERR_CHKSUM  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_DRAIN
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic          rx_valid_q;
    logic          byte_acc;
    logic [7:0]    len;
    logic [7:0]    sum;
    logic [7:0]    chk_sum;
    logic [IW-1:0] idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] rd_nx;
    logic [TW-1:0] tcount;
    logic          timed_out;
    logic          xfer;
    logic          ok_set;
    logic          err_set;
    logic [1:0]    err_code_nx;
    logic [7:0]    buffer [0:MAX_LEN-1];

    // A byte is a rising edge of the receiver's valid level; rx_valid_q resets
    // high so a level already present at reset release is not taken as a byte.
    assign byte_acc  = rx_valid && !rx_valid_q;
    assign chk_sum   = sum + rx_data;
    assign timed_out = (tcount == TIMEOUT_LAST);
    assign xfer      = out_valid && out_ready;
    assign rd_nx     = rd_idx + IW'(1);
    assign busy      = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic plus the frame_ok/frame_err strobes for the next cycle.
    always_comb begin
        state_nx    = state;
        ok_set      = 1'b0;
        err_set     = 1'b0;
        err_code_nx = err_code;
        case (state)
            S_IDLE: begin
                if (byte_acc && rx_data == SYNC_BYTE) state_nx = S_LEN;
            end
            S_LEN: begin
                if (byte_acc) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        err_set     = 1'b1;
                        err_code_nx = ERR_LENGTH;
                        state_nx    = S_IDLE;
                    end else begin
                        state_nx = S_PAYLOAD;
                    end
                end else if (timed_out) begin
                    err_set     = 1'b1;
                    err_code_nx = ERR_TIMEOUT;
                    state_nx    = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (byte_acc) begin
                    if (8'(idx) + 8'd1 == len) state_nx = S_CHECK;
                end else if (timed_out) begin
                    err_set     = 1'b1;
                    err_code_nx = ERR_TIMEOUT;
                    state_nx    = S_IDLE;
                end
            end
            S_CHECK: begin
                if (byte_acc) begin
                    if (chk_sum == 8'd0) begin
                        ok_set   = 1'b1;
                        state_nx = S_DRAIN;
                    end else begin
                        err_set     = 1'b1;
                        err_code_nx = ERR_CHKSUM;
                        state_nx    = S_IDLE;
                    end
                end else if (timed_out) begin
                    err_set     = 1'b1;
                    err_code_nx = ERR_TIMEOUT;
                    state_nx    = S_IDLE;
                end
            end
            S_DRAIN: begin
                // A byte arriving now cannot be buffered; it is dropped and reported.
                if (byte_acc) begin
                    err_set     = 1'b1;
                    err_code_nx = ERR_OVERRUN;
                end
                if (xfer && out_last) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Frame bookkeeping, timeout counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_q <= 1'b1;
            len        <= '0;
            sum        <= '0;
            idx        <= '0;
            rd_idx     <= '0;
            tcount     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
        end else begin
            rx_valid_q <= rx_valid;
            frame_ok   <= ok_set;
            frame_err  <= err_set;
            err_code   <= err_code_nx;

            // The idle timer only runs while a frame is being collected.
            if (byte_acc || state == S_IDLE || state == S_DRAIN) tcount <= '0;
            else                                                  tcount <= tcount + TW'(1);

            case (state)
                S_LEN: begin
                    if (byte_acc) begin
                        len <= rx_data;
                        sum <= rx_data;
                        idx <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (byte_acc) begin
                        sum <= chk_sum;
                        idx <= idx + IW'(1);
                    end
                end
                S_CHECK: begin
                    if (ok_set) begin
                        out_valid <= 1'b1;
                        out_data  <= buffer[0];
                        out_last  <= (len == 8'd1);
                        rd_idx    <= '0;
                    end
                end
                S_DRAIN: begin
                    if (xfer) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            rd_idx   <= rd_nx;
                            out_data <= buffer[rd_nx[AW-1:0]];
                            out_last <= (8'(rd_nx) + 8'd1 == len);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload buffer; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && byte_acc) buffer[idx[AW-1:0]] <= rx_data;
    end

`ifdef PARSER_STATS_EN
    // Saturating frame statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_count  <= '0;
            err_count <= '0;
        end else begin
            if (frame_ok && ok_count != 16'hFFFF)   ok_count  <= ok_count + 16'd1;
            if (frame_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good/bad frames, length limits,
// timeout, overrun during drain and a valid level held across reset.
// The clock ratio is scaled down so one byte time is 40 cycles and the
// mid-frame timeout is 160 cycles.
module tb_uart_frame_parser;

    localparam int BASE_FREQ = 460_800;
    localparam int BAUDRATE  = 115_200;
    localparam int MAX_LEN   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
`ifdef PARSER_STATS_EN
    logic [15:0] ok_count;
    logic [15:0] err_count;
`endif

    uart_frame_parser #(
        .BASE_FREQ     (BASE_FREQ),
        .BAUDRATE      (BAUDRATE),
        .MAX_LEN       (MAX_LEN),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_BYTES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
`ifdef PARSER_STATS_EN
        ,
        .ok_count  (ok_count),
        .err_count (err_count)
`endif
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor process).
    int         n_ok   = 0;
    int         n_err  = 0;
    int         n_both = 0;
    logic [1:0] last_code = 2'b00;
    logic [8:0] got_q[$];

    // Scoreboard state (written only by the stimulus process).
    logic [8:0] exp_q[$];
    int         rd_ptr = 0;
    logic [7:0] frm[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sample pulses and transfers on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_ok) n_ok++;
            if (frame_err) begin
                n_err++;
                last_code = err_code;
            end
            if (frame_ok && frame_err) n_both++;
            if (out_valid && out_ready) got_q.push_back({out_last, out_data});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One byte: valid goes high for one cycle; the DUT accepts it on the
    // second edge. Returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] seq[$]);
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic exp_push(input logic [7:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    task automatic check_stream(input string tag);
        while (exp_q.size() > 0) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if (rd_ptr < got_q.size()) check(tag, 32'(got_q[rd_ptr]), 32'(e));
            rd_ptr++;
        end
        check({tag, "_count"}, got_q.size(), rd_ptr);
        rd_ptr = got_q.size();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int ok0;
        int err0;

        // Reset with a valid level already high and a SYNC byte on the bus.
        rst       = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 8'hA5;
        out_ready = 1'b1;
        tick(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_frame_ok",  32'(frame_ok),  32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_code",  32'(err_code),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        rst = 1'b0;
        tick(4);
        check("held_valid_busy", 32'(busy), 32'd0);
        rx_valid = 1'b0;
        tick(2);
        check("held_valid_busy2", 32'(busy), 32'd0);
        check("held_valid_err", n_err, 0);

        // Good 3-byte frame: 03+11+22+33+97 = 0x100.
        ok0 = n_ok; err0 = n_err;
        frm = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_list(frm);
        check("t1_frame_ok",  32'(frame_ok),  32'd1);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_first",     32'(out_data),  32'h11);
        check("t1_busy",      32'(busy),      32'd1);
        exp_push(8'h11, 1'b0); exp_push(8'h22, 1'b0); exp_push(8'h33, 1'b1);
        tick(1);
        check("t1_ok_width",  32'(frame_ok),  32'd0);
        check("t1_second",    32'(out_data),  32'h22);
        tick(2);
        check("t1_valid_low", 32'(out_valid), 32'd0);
        check("t1_idle",      32'(busy),      32'd0);
        tick(3);
        check("t1_ok_cnt",  n_ok - ok0, 1);
        check("t1_err_cnt", n_err - err0, 0);
        check_stream("t1_stream");

        // Bad checksum: sum wraps to 0x01.
        ok0 = n_ok; err0 = n_err;
        frm = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
        send_list(frm);
        tick(3);
        check("t2_err_cnt", n_err - err0, 1);
        check("t2_code",    32'(last_code), 32'd2);
        check("t2_ok_cnt",  n_ok - ok0, 0);
        check("t2_no_out",  got_q.size(), rd_ptr);
        check("t2_idle",    32'(busy), 32'd0);
        // Next good frame: 02+10+20+CE = 0x100.
        ok0 = n_ok;
        frm = {8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
        send_list(frm);
        exp_push(8'h10, 1'b0); exp_push(8'h20, 1'b1);
        tick(5);
        check("t2b_ok_cnt", n_ok - ok0, 1);
        check_stream("t2b_stream");

        // Length limits: 0 and MAX_LEN+1 rejected, MAX_LEN accepted.
        err0 = n_err;
        frm = {8'hA5, 8'h00};
        send_list(frm);
        tick(2);
        check("t3_len0_err",  n_err - err0, 1);
        check("t3_len0_code", 32'(last_code), 32'd1);
        check("t3_len0_idle", 32'(busy), 32'd0);
        last_code_reset_probe: begin end
        err0 = n_err;
        frm = {8'hA5, 8'h11};
        send_list(frm);
        tick(2);
        check("t3_len17_err",  n_err - err0, 1);
        check("t3_len17_code", 32'(last_code), 32'd1);
        check("t3_len17_idle", 32'(busy), 32'd0);
        // LEN=16, payload 01..10: 0x10 + 0x88 = 0x98, CHK = 0x68.
        ok0 = n_ok;
        frm = {8'hA5, 8'h10};
        for (int i = 1; i <= 16; i++) begin
            frm.push_back(8'(i));
            exp_push(8'(i), (i == 16));
        end
        frm.push_back(8'h68);
        send_list(frm);
        tick(20);
        check("t3_max_ok", n_ok - ok0, 1);
        check_stream("t3_max_stream");

        // Timeout: stall after one payload byte; fires 160 cycles after it.
        err0 = n_err;
        frm = {8'hA5, 8'h02, 8'h44};
        send_list(frm);
        tick(150);
        check("t4_early_err", n_err - err0, 0);
        check("t4_early_busy", 32'(busy), 32'd1);
        tick(50);
        check("t4_err_cnt", n_err - err0, 1);
        check("t4_code",    32'(last_code), 32'd3);
        check("t4_idle",    32'(busy), 32'd0);
        check("t4_no_out",  got_q.size(), rd_ptr);

        // Overrun while the consumer stalls.
        out_ready = 1'b0;
        ok0 = n_ok; err0 = n_err;
        frm = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_list(frm);
        check("t5_valid", 32'(out_valid), 32'd1);
        check("t5_data0", 32'(out_data),  32'h11);
        tick(5);
        send_byte(8'h5A);
        check("t5_err_pulse", 32'(frame_err), 32'd1);
        tick(1);
        check("t5_err_cnt", n_err - err0, 1);
        check("t5_code",    32'(last_code), 32'd0);
        check("t5_hold_data",  32'(out_data),  32'h11);
        check("t5_hold_valid", 32'(out_valid), 32'd1);
        check("t5_busy",       32'(busy),      32'd1);
        tick(12);
        check("t5_hold_data2", 32'(out_data), 32'h11);
        check("t5_hold_last",  32'(out_last), 32'd0);
        check("t5_no_xfer",    got_q.size(), rd_ptr);
        out_ready = 1'b1;
        exp_push(8'h11, 1'b0); exp_push(8'h22, 1'b0); exp_push(8'h33, 1'b1);
        tick(5);
        check("t5_ok_cnt", n_ok - ok0, 1);
        check("t5_idle",   32'(busy), 32'd0);
        check_stream("t5_stream");

        // Junk before SYNC; 01+7F+81 wraps to 0x01 (rejected),
        // 01+7F+80 wraps to zero (accepted).
        send_byte(8'h55);
        check("t6_junk_idle", 32'(busy), 32'd0);
        err0 = n_err;
        frm = {8'hA5, 8'h01, 8'h7F, 8'h81};
        send_list(frm);
        tick(2);
        check("t6_bad_err",  n_err - err0, 1);
        check("t6_bad_code", 32'(last_code), 32'd2);
        ok0 = n_ok;
        frm = {8'h55, 8'hA5, 8'h01, 8'h7F, 8'h80};
        send_list(frm);
        check("t6_single_last", 32'(out_last), 32'd1);
        exp_push(8'h7F, 1'b1);
        tick(4);
        check("t6_ok_cnt", n_ok - ok0, 1);
        check("t6_idle",   32'(busy), 32'd0);
        check_stream("t6_stream");

        check("ok_err_same_cycle", n_both, 0);
`ifdef PARSER_STATS_EN
        check("stats_ok",  32'(ok_count),  n_ok);
        check("stats_err", 32'(err_count), n_err);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
